// File: rtl/ob_unloader_if.sv
// Row stream from the output-buffer unloader to its sink: one memory row per beat,
// last marks the final row of a transfer.
interface ob_unloader_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/ob_unloader.sv
// Drains rows from the output buffer SRAM and streams them over a valid/ready stream.
// Optional OB_UNLOAD_STALL_CNT_EN adds stall_cnt_o, a saturating count of stalled beats.
module ob_unloader #(
  parameter int COL       = 4,
  parameter int OUT_WIDTH = 16,
  parameter int O_SIZE    = 256,
  parameter int AW        = $clog2(O_SIZE)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     start_i,
  input  logic [AW-1:0]            base_addr_i,
  input  logic [AW:0]              num_rows_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     ob_mem_cenb_o,
  output logic                     ob_mem_wenb_o,
  output logic [AW-1:0]            ob_mem_addr_o,
  input  logic [COL*OUT_WIDTH-1:0] ob_mem_data_i,
`ifdef OB_UNLOAD_STALL_CNT_EN
  output logic [15:0]              stall_cnt_o,
`endif
  ob_unloader_if.master            m
);

  localparam int DW = COL * OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t        state_r, state_nxt;
  logic [AW-1:0] base_r;
  logic [AW:0]   num_rows_r;
  logic [AW:0]   issued_r;
  logic          inflight_r;
  logic          inflight_last_r;
  logic [DW-1:0] fifo_data_r [2];
  logic [1:0]    fifo_last_r;
  logic          rd_ptr_r;
  logic          wr_ptr_r;
  logic [1:0]    fifo_count_r;

  logic       start_ok;
  logic       pop;
  logic       push;
  logic       issue;
  logic       issue_last;
  logic [2:0] occupancy;

  assign m.valid = (fifo_count_r != 2'd0);
  assign m.data  = fifo_data_r[rd_ptr_r];
  assign m.last  = m.valid & fifo_last_r[rd_ptr_r];

  // Occupancy counts rows buffered plus in flight, net of this cycle's pop, so the
  // 2-entry FIFO can never be asked to hold a third row.
  always_comb begin
    start_ok   = (state_r == IDLE) && start_i;
    pop        = m.valid & m.ready;
    push       = inflight_r;
    occupancy  = 3'(fifo_count_r) + 3'(inflight_r) - 3'(pop);
    issue      = (state_r == RUN) && (issued_r < num_rows_r) && (occupancy < 3'd2);
    issue_last = (issued_r == (num_rows_r - {{AW{1'b0}}, 1'b1}));
  end

  assign ob_mem_cenb_o = ~issue;
  assign ob_mem_wenb_o = 1'b1;
  assign ob_mem_addr_o = issue ? (base_r + issued_r[AW-1:0]) : '0;
  assign busy_o        = (state_r == RUN);
  assign done_o        = (state_r == FINISH);

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start_i) state_nxt = (num_rows_i == '0) ? FINISH : RUN;
      RUN:     if (pop && m.last) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r         <= IDLE;
      base_r          <= '0;
      num_rows_r      <= '0;
      issued_r        <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r         <= state_nxt;
      inflight_r      <= issue;
      inflight_last_r <= issue & issue_last;
      if (start_ok) begin
        base_r     <= base_addr_i;
        num_rows_r <= num_rows_i;
        issued_r   <= '0;
      end else if (issue) begin
        issued_r <= issued_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // The last flag travels with the data so m.last needs no row comparison at the head.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < 2; i++) fifo_data_r[i] <= '0;
      fifo_last_r  <= '0;
      rd_ptr_r     <= 1'b0;
      wr_ptr_r     <= 1'b0;
      fifo_count_r <= '0;
    end else begin
      if (push) begin
        fifo_data_r[wr_ptr_r] <= ob_mem_data_i;
        fifo_last_r[wr_ptr_r] <= inflight_last_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (pop) rd_ptr_r <= ~rd_ptr_r;
      fifo_count_r <= fifo_count_r + 2'(push) - 2'(pop);
    end
  end

`ifdef OB_UNLOAD_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      stall_cnt_o <= '0;
    end else if ((state_r == RUN) && m.valid && !m.ready && (stall_cnt_o != 16'hFFFF)) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ob_unloader.sv
// Scoreboard bench for ob_unloader: expected rows and read addresses are queued at start,
// a negedge monitor compares every read, beat and done pulse against them.
module tb_ob_unloader;
  localparam int COL       = 4;
  localparam int OUT_WIDTH = 16;
  localparam int O_SIZE    = 256;
  localparam int AW        = 8;
  localparam int DW        = COL * OUT_WIDTH;

  logic          clk_i       = 1'b0;
  logic          rstn_i      = 1'b0;
  logic          start_i     = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [AW:0]   num_rows_i  = '0;
  logic          busy_o;
  logic          done_o;
  logic          ob_mem_cenb_o;
  logic          ob_mem_wenb_o;
  logic [AW-1:0] ob_mem_addr_o;
  logic [DW-1:0] ob_mem_data_i = '0;
`ifdef OB_UNLOAD_STALL_CNT_EN
  logic [15:0]   stall_cnt_o;
`endif

  ob_unloader_if #(.DATA_W(DW)) m_if ();

  always #5 clk_i = ~clk_i;

  ob_unloader #(.COL(COL), .OUT_WIDTH(OUT_WIDTH), .O_SIZE(O_SIZE), .AW(AW)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .num_rows_i    (num_rows_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .ob_mem_cenb_o (ob_mem_cenb_o),
    .ob_mem_wenb_o (ob_mem_wenb_o),
    .ob_mem_addr_o (ob_mem_addr_o),
    .ob_mem_data_i (ob_mem_data_i),
`ifdef OB_UNLOAD_STALL_CNT_EN
    .stall_cnt_o   (stall_cnt_o),
`endif
    .m             (m_if.master)
  );

  // Output buffer SRAM model with one cycle of read latency
  logic [DW-1:0] mem [O_SIZE];
  always @(posedge clk_i) if (!ob_mem_cenb_o) ob_mem_data_i <= mem[ob_mem_addr_o];

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  beat_t         exp_q[$];
  logic [AW-1:0] addr_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0, start_cyc = -1, first_valid_cyc = -1, first_read_cyc = -1, last_read_cyc = -1;
  int last_acc_cyc = -1, done_cyc = -1, done_cnt = 0, reads = 0, beats = 0, stall_model = 0;
  int ready_mode = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sink ready: 0 = always high, 1 = pattern 1,0,0 repeating, 2 = random (mostly high)
  initial begin
    int ph = 0;
    m_if.ready = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       m_if.ready = 1'b1;
        1:       m_if.ready = (ph % 3 == 0);
        default: m_if.ready = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
    end
  end

  always @(negedge clk_i) begin
    cyc++;
    if (rstn_i) begin
      beat_t b;
      if (start_i && !busy_o && !done_o) start_cyc = cyc;
      if (!ob_mem_cenb_o) begin
        reads++;
        if (reads == 1) first_read_cyc = cyc;
        last_read_cyc = cyc;
        checkOutput("wenb_high_on_read", ob_mem_wenb_o, 1);
        if (addr_q.size() == 0) checkOutput("unexpected_read", 1, 0);
        else checkOutput("read_addr", ob_mem_addr_o, addr_q.pop_front());
      end
      if (m_if.valid && prev_stall) begin
        checkOutput("hold_data", m_if.data, prev_data);
        checkOutput("hold_last", m_if.last, prev_last);
      end
      if (m_if.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_if.valid && m_if.ready) begin
        beats++;
        if (m_if.last) last_acc_cyc = cyc;
        if (exp_q.size() == 0) checkOutput("unexpected_beat", 1, 0);
        else begin
          b = exp_q.pop_front();
          checkOutput("beat_data", m_if.data, b.data);
          checkOutput("beat_last", m_if.last, b.last);
        end
      end
      checkOutput("outstanding_le2", ((reads - beats) <= 2), 1);
      if (busy_o && m_if.valid && !m_if.ready) stall_model++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_if.valid && !m_if.ready;
      prev_data  = m_if.data;
      prev_last  = m_if.last;
    end
  end

  task automatic checkReset();
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_cenb", ob_mem_cenb_o, 1);
    checkOutput("rst_wenb", ob_mem_wenb_o, 1);
    checkOutput("rst_addr", ob_mem_addr_o, 0);
    checkOutput("rst_valid", m_if.valid, 0);
    checkOutput("rst_data", m_if.data, 0);
    checkOutput("rst_last", m_if.last, 0);
`ifdef OB_UNLOAD_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt_o, 0);
`endif
  endtask

  task automatic applyStimulus(input int base, input int n, input int mode);
    ready_mode = mode;
    @(posedge clk_i); #1;
    reads = 0; beats = 0; stall_model = 0;
    first_valid_cyc = -1; first_read_cyc = -1; last_read_cyc = -1;
    last_acc_cyc = -1; start_cyc = -1; done_cyc = -1;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.data = mem[(base + k) % O_SIZE];
      b.last = (k == n - 1);
      exp_q.push_back(b);
      addr_q.push_back(AW'((base + k) % O_SIZE));
    end
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    num_rows_i  = (AW+1)'(n);
    @(posedge clk_i); #1;
    start_i     = 1'b0;
    base_addr_i = AW'($urandom);
    num_rows_i  = (AW+1)'($urandom_range(1, O_SIZE));
  endtask

  task automatic finishTransfer(input int n, input int d0, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk_i); #1;
      if (done_cnt != d0) break;
    end
    checkOutput("done_seen", (done_cnt != d0), 1);
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("done_once", done_cnt - d0, 1);
    checkOutput("start_accepted", (start_cyc >= 0), 1);
    checkOutput("rows_left", exp_q.size(), 0);
    checkOutput("reads_left", addr_q.size(), 0);
    checkOutput("read_count", reads, n);
    checkOutput("beat_count", beats, n);
    checkOutput("busy_after_done", busy_o, 0);
    if (n > 0) begin
      checkOutput("first_valid_lat", first_valid_cyc - start_cyc, 3);
      checkOutput("first_read_lat", first_read_cyc - start_cyc, 1);
      checkOutput("done_after_last", done_cyc - last_acc_cyc, 1);
      if (ready_mode == 0) checkOutput("reads_back_to_back", last_read_cyc - first_read_cyc, n - 1);
    end else begin
      checkOutput("zero_len_done_lat", ((done_cyc - start_cyc) >= 1) && ((done_cyc - start_cyc) <= 2), 1);
    end
`ifdef OB_UNLOAD_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt_o, stall_model);
`endif
  endtask

  initial begin
    int d0;
    for (int k = 0; k < O_SIZE; k++) mem[k] = {4{16'(k + 1)}};
    repeat (3) @(posedge clk_i);
    #1;
    checkReset();
    rstn_i = 1'b1;

    $display("[TB] basic");
    d0 = done_cnt;
    applyStimulus(0, 4, 0);
    finishTransfer(4, d0, 50);

    for (int k = 0; k < O_SIZE; k++) mem[k] = {$urandom, $urandom};

    $display("[TB] backpressure");
    d0 = done_cnt;
    applyStimulus(int'($urandom_range(0, 255)), 6, 1);
    finishTransfer(6, d0, 100);

    $display("[TB] wrap");
    d0 = done_cnt;
    applyStimulus(254, 4, 0);
    finishTransfer(4, d0, 50);

    $display("[TB] zero length");
    d0 = done_cnt;
    applyStimulus(7, 0, 0);
    finishTransfer(0, d0, 20);

    $display("[TB] full size with ignored restart");
    d0 = done_cnt;
    applyStimulus(int'($urandom_range(0, 255)), 256, 2);
    repeat (50) @(posedge clk_i);
    #1;
    start_i    = 1'b1;
    num_rows_i = 9'd5;
    @(posedge clk_i); #1;
    start_i    = 1'b0;
    finishTransfer(256, d0, 3000);

    $display("[TB] random transfers");
    for (int t = 0; t < 5; t++) begin
      int n;
      n  = int'($urandom_range(1, 20));
      d0 = done_cnt;
      applyStimulus(int'($urandom_range(0, 255)), n, 2);
      finishTransfer(n, d0, 400);
    end

    $display("[TB] reset mid-transfer");
    d0 = done_cnt;
    applyStimulus(int'($urandom_range(0, 255)), 8, 0);
    for (int i = 0; i < 50 && beats < 3; i++) begin
      @(posedge clk_i); #1;
    end
    checkOutput("beats_before_reset", beats, 3);
    rstn_i = 1'b0;
    #1;
    checkReset();
    exp_q.delete();
    addr_q.delete();
    prev_stall = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("no_done_on_abort", done_cnt - d0, 0);
    d0 = done_cnt;
    applyStimulus(int'($urandom_range(0, 255)), 2, 0);
    finishTransfer(2, d0, 50);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
